// File: rtl/rv_pkg.sv
// Shared core definitions: default widths, reset vector, PC FSM states and alignment mask.
package rv_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned RESET_VEC_DEF = 0;

  // Low address bits that must be zero for a 4-byte aligned instruction address.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_gen_if.sv
// Instruction-memory fetch handshake (same-cycle req/gnt).
//   imem_req_o  : fetch request, held until granted
//   imem_addr_o : fetch address, stable while the request is outstanding
//   imem_gnt_i  : memory accepts the current request this cycle
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i
  );

endinterface

// File: rtl/pc_gen.sv
// Program counter and fetch-request generator.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall_i             : hold PC, suppress issue of a new request
//   branch_i/_addr_i    : taken branch and target (must be 4-byte aligned)
//   trap_i/_addr_i      : trap redirect and vector (low 2 bits forced to 0)
//   imem                : fetch handshake (master side)
//   pc_o                : current PC (same as imem_addr_o)
//   fetch_valid_o/_kill_o : qualification of the fetch accepted this cycle
//   misalign_o          : one-cycle pulse after a misaligned branch target
module pc_gen
  import rv_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter int unsigned     STEP      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_addr_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_addr_i,
  pc_gen_if.master        imem,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_valid_o,
  output logic            fetch_kill_o,
  output logic            misalign_o
);

  localparam logic [XLEN-1:0] ADDR_MASK = ~XLEN'(ALIGN_MASK);
  localparam logic [XLEN-1:0] STEP_W    = XLEN'(STEP);

  pc_state_t       state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_addr_q;
  logic            pend_trap_q;
  logic            outst_q;
  logic            misalign_q;

  logic            br_misaligned;
  logic            br_ok;
  logic [XLEN-1:0] trap_tgt;
  logic            redir_vld;
  logic [XLEN-1:0] redir_tgt;
  logic            req;
  logic            gnt;
  logic            acc;
  logic [XLEN-1:0] pend_addr_nxt;
  logic            pend_trap_nxt;

  assign gnt = imem.imem_gnt_i;

  // Redirect priority: trap > aligned branch > none.
  always_comb begin
    br_misaligned = |(branch_addr_i[1:0] & ALIGN_MASK);
    br_ok         = branch_i & ~br_misaligned;
    trap_tgt      = trap_addr_i & ADDR_MASK;
    redir_vld     = trap_i | br_ok;
    redir_tgt     = trap_i ? trap_tgt : branch_addr_i;
  end

  // Request: held while outstanding, forced in PEND, gated by stall in RUN.
  always_comb begin
    req = 1'b0;
    unique case (state_q)
      START:   req = 1'b0;
      RUN:     req = outst_q | ~stall_i;
      PEND:    req = 1'b1;
      default: req = 1'b0;
    endcase
  end

  // Pending redirect update: a trap always overwrites, a branch only if no trap is latched.
  always_comb begin
    pend_addr_nxt = pend_addr_q;
    pend_trap_nxt = pend_trap_q;
    if (trap_i) begin
      pend_addr_nxt = trap_tgt;
      pend_trap_nxt = 1'b1;
    end else if (br_ok && !pend_trap_q) begin
      pend_addr_nxt = branch_addr_i;
    end
  end

  // Fetch qualification: anything accepted in PEND or alongside a redirect is wrong-path.
  always_comb begin
    acc           = req & gnt;
    fetch_kill_o  = acc & ((state_q == PEND) | redir_vld);
    fetch_valid_o = acc & ~fetch_kill_o;
  end

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = pc_q;
  assign pc_o             = pc_q;
  assign misalign_o       = misalign_q;

  // PC state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= START;
      pc_q        <= RESET_VEC;
      pend_addr_q <= '0;
      pend_trap_q <= 1'b0;
      outst_q     <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      outst_q    <= req & ~gnt;
      misalign_q <= (state_q != START) & branch_i & ~trap_i & br_misaligned;
      unique case (state_q)
        START: state_q <= RUN;
        RUN: begin
          if (redir_vld) begin
            if (req && !gnt) begin
              pend_addr_q <= redir_tgt;
              pend_trap_q <= trap_i;
              state_q     <= PEND;
            end else begin
              pc_q <= redir_tgt;
            end
          end else if (acc) begin
            pc_q <= pc_q + STEP_W;
          end
        end
        PEND: begin
          if (gnt) begin
            pc_q        <= pend_addr_nxt;
            pend_addr_q <= '0;
            pend_trap_q <= 1'b0;
            state_q     <= RUN;
          end else begin
            pend_addr_q <= pend_addr_nxt;
            pend_trap_q <= pend_trap_nxt;
          end
        end
        default: state_q <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        trap_i;
  logic [31:0] trap_addr_i;
  logic [31:0] pc_o;
  logic        fetch_valid_o;
  logic        fetch_kill_o;
  logic        misalign_o;

  int n_tests = 0;
  int n_fail  = 0;

  pc_gen_if #(.XLEN(32)) imem ();

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .STEP(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .trap_i        (trap_i),
    .trap_addr_i   (trap_addr_i),
    .imem          (imem),
    .pc_o          (pc_o),
    .fetch_valid_o (fetch_valid_o),
    .fetch_kill_o  (fetch_kill_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle's inputs after the falling edge and let combinational outputs settle.
  task automatic drive(input logic s, input logic b, input logic [31:0] ba,
                       input logic t, input logic [31:0] ta, input logic g);
    @(negedge clk);
    stall_i       = s;
    branch_i      = b;
    branch_addr_i = ba;
    trap_i        = t;
    trap_addr_i   = ta;
    imem.imem_gnt_i = g;
    #1;
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] addr,
                           input logic req, input logic vld, input logic kill);
    check({tag, ".addr"}, imem.imem_addr_o, addr);
    check({tag, ".req"},  32'(imem.imem_req_o), 32'(req));
    check({tag, ".vld"},  32'(fetch_valid_o), 32'(vld));
    check({tag, ".kill"}, 32'(fetch_kill_o), 32'(kill));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    stall_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
    trap_i = 1'b0; trap_addr_i = '0; imem.imem_gnt_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_fetch("rst", 32'h0, 1'b0, 1'b0, 1'b0);
    check("rst.pc", pc_o, 32'h0);
    check("rst.mis", 32'(misalign_o), 32'h0);

    // Reset release: START cycle, then sequential fetches with gnt=1.
    @(negedge clk); rst_n = 1'b1; #1;
    chk_fetch("start", 32'h0, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 0, 1); chk_fetch("seq0", 32'h0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 1); chk_fetch("seq4", 32'h4, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 1); chk_fetch("seq8", 32'h8, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 1); chk_fetch("seqc", 32'hc, 1, 1, 0);

    // Held request at 0x10 for three ungranted cycles, stall raised mid-wait.
    drive(0, 0, 0, 0, 0, 0); chk_fetch("hold0", 32'h10, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0); chk_fetch("hold1", 32'h10, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0); chk_fetch("hold2", 32'h10, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 1); chk_fetch("holdg", 32'h10, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 1); chk_fetch("stall0", 32'h14, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1); chk_fetch("stall1", 32'h14, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1); chk_fetch("seq14", 32'h14, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 1); chk_fetch("seq18", 32'h18, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 1); chk_fetch("seq1c", 32'h1c, 1, 1, 0);

    // Deferred redirect: branch while the fetch at 0x20 waits for grant.
    drive(0, 1, 32'h100, 0, 0, 0); chk_fetch("def0", 32'h20, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1);       chk_fetch("defg", 32'h20, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0);       chk_fetch("def1", 32'h100, 1, 0, 0);

    // Priority in PEND: pending 0x100, then trap 0x803, then branch 0x200.
    drive(0, 1, 32'h100, 0, 0, 0);       check("pri0.pc", pc_o, 32'h100);
    drive(1, 0, 0, 1, 32'h803, 0);       chk_fetch("pri1", 32'h100, 1, 0, 0);
    drive(1, 1, 32'h200, 0, 0, 0);       chk_fetch("pri2", 32'h100, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1);             chk_fetch("prig", 32'h100, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 1);             chk_fetch("pri3", 32'h800, 1, 1, 0);

    // Misaligned branch: ignored, one-cycle pulse, sequential flow continues.
    drive(0, 1, 32'h42, 0, 0, 1); chk_fetch("mis0", 32'h804, 1, 1, 0);
    check("mis0.mis", 32'(misalign_o), 32'h0);
    drive(0, 0, 0, 0, 0, 1); chk_fetch("mis1", 32'h808, 1, 1, 0);
    check("mis1.mis", 32'(misalign_o), 32'h1);
    drive(0, 0, 0, 0, 0, 0); check("mis2.mis", 32'(misalign_o), 32'h0);
    check("mis2.pc", pc_o, 32'h80c);

    // Async reset in PEND, between clock edges.
    drive(0, 1, 32'h300, 0, 0, 0); chk_fetch("ar0", 32'h80c, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);       chk_fetch("ar1", 32'h80c, 1, 0, 0);
    #2; imem.imem_gnt_i = 1'b1; rst_n = 1'b0; #1;
    chk_fetch("arst", 32'h0, 0, 0, 0);
    check("arst.pc", pc_o, 32'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk_fetch("ar.start", 32'h0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1); chk_fetch("ar.seq0", 32'h0, 1, 1, 0);

    // Unblocked trap: vector low bits cleared, one-cycle latency, current fetch killed.
    drive(0, 1, 32'h40, 1, 32'h1f3, 1); chk_fetch("trap0", 32'h4, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 1);            chk_fetch("trap1", 32'h1f0, 1, 1, 0);
    check("trap1.mis", 32'(misalign_o), 32'h0);

    // Redirect while stalled with nothing outstanding: taken, then held.
    drive(1, 1, 32'h400, 0, 0, 1); chk_fetch("rs0", 32'h1f4, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1);       chk_fetch("rs1", 32'h400, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);       chk_fetch("rs2", 32'h400, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter and fetch-request generator for the single-cycle/pipelined RISC-V cores. It generates the next fetch address and requests it from instruction memory through a req/gnt handshake. It keeps each request stable until granted, resolves redirects by priority (trap > branch > sequential), and defers redirects that arrive while a fetch is outstanding. It sits between the branch/trap logic in execute and the instruction-memory port, and feeds the fetched PC to decode.

## Interface
- `XLEN`, 32: PC and address width.
- `RESET_VEC`, 0: PC value after reset; must be 4-byte aligned.
- `STEP`, 4: sequential increment in bytes.

- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall_i`  in  1  hold PC; suppresses issue of a new request.
- `branch_i`  in  1  branch/jump taken this cycle.
- `branch_addr_i`  in  XLEN  branch target.
- `trap_i`  in  1  trap/exception redirect this cycle.
- `trap_addr_i`  in  XLEN  trap vector; low 2 bits are forced to 0.
- `imem_gnt_i`  in  1  memory accepts the current request this cycle.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  XLEN  fetch address; equals `pc_o`.
- `pc_o`  out  XLEN  current PC.
- `fetch_valid_o`  out  1  accepted fetch is on the correct path.
- `fetch_kill_o`  out  1  accepted fetch is wrong-path; decode drops it.
- `misalign_o`  out  1  one-cycle pulse: branch target not 4-byte aligned.

## Operation
- **States:**
  - START: one cycle after reset release; `imem_req_o`=0.
  - RUN: normal operation.
  - PEND: a redirect is latched while a request is outstanding.
- **Reset values:** state START, `pc_o`=RESET_VEC, `imem_req_o`=0, pending regs 0, `misalign_o`=0, `fetch_valid_o`/`fetch_kill_o`=0.
- **START → RUN** unconditionally.
- **Outstanding request:** `imem_req_o` was 1 last cycle and `imem_gnt_i` was 0.
- **Request generation:**
  - RUN: `imem_req_o` = outstanding | !stall_i.
  - PEND: `imem_req_o`=1.
  - While outstanding, neither `imem_req_o` nor `imem_addr_o` may change.
- **Effective redirect:**
  - If `trap_i`: target = trap_addr_i & ~3.
  - Else if `branch_i` and branch_addr_i[1:0]==0: target = branch_addr_i.
  - Else no redirect.
- **Misaligned branch:** branch_i with branch_addr_i[1:0]!=0 and no trap.
  - Redirect is ignored.
  - `misalign_o`=1 next cycle, for exactly one cycle.
- **PC update in RUN:**
  - Redirect and (no request, or req&&gnt): `pc_o` ← target.
  - Redirect and req&&!gnt: pending ← target, go to PEND, `pc_o` unchanged.
  - No redirect and req&&gnt: `pc_o` ← `pc_o`+STEP (wraps modulo 2^XLEN).
  - Otherwise `pc_o` holds.
- **In PEND:**
  - New trap: overwrites pending.
  - New branch: overwrites pending only if no trap is pending.
  - On gnt: `pc_o` ← pending, go to RUN.
  - stall_i is ignored.
- **Fetch qualification (combinational):**
  - acc = `imem_req_o` & `imem_gnt_i`.
  - `fetch_kill_o` = acc & (state==PEND | effective redirect this cycle).
  - `fetch_valid_o` = acc & !`fetch_kill_o`.

## Timing
- Grant is same-cycle. The PC advances on the rising edge after req&&gnt, so back-to-back grants give one fetch per cycle.
- Redirect latency when not blocked: target appears on `imem_addr_o` one cycle after `branch_i`/`trap_i`.
- Redirect blocked by an outstanding fetch: target appears the cycle after that fetch's grant.
- stall_i asserted with no outstanding request: `imem_req_o` drops in the same cycle.
- Redirect and stall_i in the same cycle: the redirect is still taken. The new PC is then held until stall_i deasserts.
- Reset mid-operation: all outputs take their reset values immediately (asynchronous), and pending redirects are discarded. Memory must ignore the dropped request.

## Structure
- Shared package `rv_pkg`:
  - `XLEN` default.
  - `RESET_VEC` default.
  - State enum `pc_state_t` {START, RUN, PEND}.
  - Alignment mask constant.
- Single module, no sub-module. The redirect priority mux may be a function inside `pc_gen`.

## Test plan
- **Reset/start:** release rst_n, gnt=1 always.
  - START cycle has req=0, addr=0.
  - Then addr 0x0, 0x4, 0x8 on consecutive cycles, `fetch_valid_o`=1 each.
- **Held request:** req at 0x10, gnt=0 for 3 cycles, stall_i=1 mid-wait.
  - req stays 1 and addr stays 0x10 throughout.
  - After gnt, PC holds at 0x14 while stall_i=1.
- **Deferred redirect:** at 0x20 with gnt=0, branch_i to 0x100.
  - `pc_o` stays 0x20.
  - The grant at 0x20 gives `fetch_kill_o`=1.
  - Next cycle addr=0x100.
- **Priority:** in PEND with pending 0x100, trap_i to 0x803, then branch_i to 0x200.
  - After gnt, addr=0x800.
- **Misaligned branch:** branch_i to 0x42 in RUN with gnt=1.
  - `misalign_o` pulses for one cycle.
  - PC continues sequentially.
- **Async reset:** assert rst_n low mid-PEND, between clock edges.
  - Outputs go to reset values immediately.
  - After release, fetch restarts at RESET_VEC.
